// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor path: direction codes (also used by the
// joystick decoder), FSM state encoding and a code-validity helper.
package cursor_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Only the four one-hot codes are real presses; anything else reads as none.
    function automatic logic dir_valid(input logic [3:0] d);
        return (d == DIR_LEFT) || (d == DIR_RIGHT) || (d == DIR_DOWN) || (d == DIR_UP);
    endfunction

endpackage

// File: rtl/cursor_step_controller_tick_gen.sv
// tick_gen: free-running strobe divider. tick is high for one clk out of
// every TICK_DIV; it is never restarted by anything but rst.
module tick_gen
    import cursor_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div;

    // Divider counts 0..TICK_DIV-1 and rolls over.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == LAST) begin
            div <= '0;
        end else begin
            div <= div + CW'(1);
        end
    end

    assign tick = (div == LAST);

endmodule

// File: rtl/cursor_step_controller.sv
// cursor_step_controller: turns registered joystick direction codes into
// cursor steps with press / hold-delay / auto-repeat timing.
// Optional feature: define CURSOR_WRAP_EN to wrap at the grid edges instead of
// blocking the step.
// Handshake: none; directions is a level sampled every clk, step_pulse is a
// one-cycle strobe that accompanies every change of cur_x/cur_y.
// fsm_state exposes the internal state for observation only.
module cursor_step_controller
    import cursor_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int DELAY_TICKS  = 400,
    parameter int REPEAT_TICKS = 100,
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 16,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    directions,
    input  logic          enable,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          step_pulse,
    output logic [3:0]    step_dir,
    output state_t        fsm_state
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int            MAXT        = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
    localparam int            CW          = $clog2(MAXT + 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
    localparam logic [XW-1:0] X_MAX       = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX       = YW'(GRID_H - 1);

    logic          tick;
    state_t        state, state_n;
    logic [3:0]    dir_q, held, held_n, code, step_code, sdir_n;
    logic [CW-1:0] cnt, cnt_n, last_cnt;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic          pulse_n, do_step, moved;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // State, counters, captured input and cursor outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            held       <= DIR_NONE;
            dir_q      <= DIR_NONE;
            cur_x      <= '0;
            cur_y      <= '0;
            step_pulse <= 1'b0;
            step_dir   <= DIR_NONE;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            held       <= held_n;
            dir_q      <= directions;
            cur_x      <= x_n;
            cur_y      <= y_n;
            step_pulse <= pulse_n;
            step_dir   <= sdir_n;
        end
    end

    // Next state, step decision and the position update it produces.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        held_n    = held;
        x_n       = cur_x;
        y_n       = cur_y;
        pulse_n   = 1'b0;
        sdir_n    = step_dir;
        do_step   = 1'b0;
        moved     = 1'b0;
        step_code = held;
        code      = dir_valid(dir_q) ? dir_q : DIR_NONE;
        last_cnt  = (state == ST_HOLD) ? DELAY_LAST : REPEAT_LAST;

        case (state)
            ST_IDLE: begin
                if (enable && code != DIR_NONE) begin
                    do_step   = 1'b1;
                    step_code = code;
                    held_n    = code;
                    cnt_n     = '0;
                    state_n   = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!enable || code == DIR_NONE) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (code != held) begin
                    // A different direction is a fresh press.
                    do_step   = 1'b1;
                    step_code = code;
                    held_n    = code;
                    cnt_n     = '0;
                    state_n   = ST_HOLD;
                end else if (tick) begin
                    if (cnt == last_cnt) begin
                        do_step = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_REPEAT;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (do_step) begin
            case (step_code)
                DIR_LEFT: begin
                    if (cur_x != '0)  begin x_n = cur_x - XW'(1); moved = 1'b1; end
                    else if (WRAP)    begin x_n = X_MAX;          moved = 1'b1; end
                end
                DIR_RIGHT: begin
                    if (cur_x != X_MAX) begin x_n = cur_x + XW'(1); moved = 1'b1; end
                    else if (WRAP)      begin x_n = '0;             moved = 1'b1; end
                end
                DIR_UP: begin
                    if (cur_y != '0)  begin y_n = cur_y - YW'(1); moved = 1'b1; end
                    else if (WRAP)    begin y_n = Y_MAX;          moved = 1'b1; end
                end
                DIR_DOWN: begin
                    if (cur_y != Y_MAX) begin y_n = cur_y + YW'(1); moved = 1'b1; end
                    else if (WRAP)      begin y_n = '0;             moved = 1'b1; end
                end
                default: moved = 1'b0;
            endcase
            if (moved) begin
                pulse_n = 1'b1;
                sdir_n  = step_code;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_cursor_step_controller.sv
// Bench for cursor_step_controller with TICK_DIV=4, DELAY_TICKS=3,
// REPEAT_TICKS=2 on an 8x8 grid. A tick-counting reference model predicts the
// outputs after every clock edge; directed scenarios add fixed expectations.
module tb_cursor_step_controller;
    import cursor_pkg::*;

    localparam int TD = 4;
    localparam int DL = 3;
    localparam int RP = 2;
    localparam int GW = 8;
    localparam int GH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] directions;
    logic       enable;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic       step_pulse;
    logic [3:0] step_dir;
    state_t     fsm_state;

    logic [12:0] obs_v;
    logic [12:0] exp_v;
    logic [12:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    // Reference model: press tracking counted in ticks since the press.
    logic [3:0] m_dq;
    bit         m_active;
    logic [3:0] m_held;
    int         m_n, m_cyc, ex, ey;
    bit         ep;
    logic [3:0] ed;

    cursor_step_controller #(
        .TICK_DIV(TD), .DELAY_TICKS(DL), .REPEAT_TICKS(RP), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .clk(clk), .rst(rst), .directions(directions), .enable(enable),
        .cur_x(cur_x), .cur_y(cur_y), .step_pulse(step_pulse), .step_dir(step_dir),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign obs_v = {cur_x, cur_y, step_pulse, step_dir, fsm_state};

    // One clock: advance the model on the edge, push its prediction, settle to negedge.
    task automatic run_cycle();
        logic [3:0] code;
        bit tick, fire, moved;
        int nx, ny;
        logic [1:0] est;
        @(posedge clk);
        if (rst) begin
            ex = 0; ey = 0; ep = 0; ed = 4'b0000;
            m_active = 0; m_n = 0; m_cyc = 0; m_dq = 4'b0000; m_held = 4'b0000;
        end else begin
            code = ($countones(m_dq) == 1) ? m_dq : 4'b0000;
            tick = (m_cyc % TD) == TD - 1;
            fire = 0;
            if (!enable || code == 4'b0000) begin
                m_active = 0;
            end else if (!m_active || code != m_held) begin
                m_active = 1; m_held = code; m_n = 0; fire = 1;
            end else if (tick) begin
                m_n++;
                if (m_n == DL || (m_n > DL && (m_n - DL) % RP == 0)) fire = 1;
            end
            ep = 0;
            if (fire) begin
                nx = ex; ny = ey;
                if (code == DIR_LEFT)  nx = ex - 1;
                if (code == DIR_RIGHT) nx = ex + 1;
                if (code == DIR_UP)    ny = ey - 1;
                if (code == DIR_DOWN)  ny = ey + 1;
`ifdef CURSOR_WRAP_EN
                nx = (nx + GW) % GW; ny = (ny + GH) % GH; moved = 1;
`else
                moved = (nx >= 0) && (nx < GW) && (ny >= 0) && (ny < GH);
`endif
                if (moved) begin ex = nx; ey = ny; ep = 1; ed = code; end
            end
            m_dq = directions;
            m_cyc++;
        end
        est = !m_active ? 2'd0 : (m_n < DL ? 2'd1 : 2'd2);
        exp_q.push_back({3'(ex), 3'(ey), ep, ed, est});
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; directions = 4'b0000; enable = 1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== 13'd0) $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs_v, 13'd0);
            else passes++;
        end
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== 13'd0) $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs_v, 13'd0);
            else passes++;
        end
    endtask

    task automatic test_single_press();
        int pulses = 0;
        for (int i = 0; i < 32; i++) begin
            directions = (i < 2) ? DIR_RIGHT : DIR_NONE;
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (step_pulse) pulses++;
            if (obs_v !== exp_v) $display("FAIL single_press cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        checks++;
        if (pulses !== 1 || cur_x !== 3'd1 || step_dir !== DIR_RIGHT)
            $display("FAIL single_press_end: got pulses=%0d x=%0d dir=%b want 1 1 0100", pulses, cur_x, step_dir);
        else passes++;
    endtask

    task automatic test_hold_saturate();
        int pulses = 0, first = -1, second = -1;
        rst = 1; directions = DIR_NONE;
        for (int i = 0; i < 2; i++) begin run_cycle(); void'(exp_q.pop_front()); end
        rst = 0; directions = DIR_RIGHT;
        for (int i = 1; i <= 200; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (step_pulse) begin
                pulses++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (obs_v !== exp_v) $display("FAIL hold_right cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        checks++;
        if (first !== 2 || second !== 12)
            $display("FAIL hold_timing: got first=%0d second=%0d want 2 12", first, second);
        else passes++;
        checks++;
        if (pulses !== 7 || cur_x !== 3'd7)
            $display("FAIL hold_saturate: got pulses=%0d x=%0d want 7 7", pulses, cur_x);
        else passes++;
        directions = DIR_NONE;
    endtask

    task automatic test_left_edge();
        int pulses = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin run_cycle(); void'(exp_q.pop_front()); end
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            directions = (i < 3) ? DIR_LEFT : DIR_NONE;
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (step_pulse) pulses++;
            if (obs_v !== exp_v) $display("FAIL left_edge cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        checks++;
`ifdef CURSOR_WRAP_EN
        if (pulses !== 1 || cur_x !== 3'd7)
            $display("FAIL left_wrap: got pulses=%0d x=%0d want 1 7", pulses, cur_x);
`else
        if (pulses !== 0 || cur_x !== 3'd0)
            $display("FAIL left_block: got pulses=%0d x=%0d want 0 0", pulses, cur_x);
`endif
        else passes++;
    endtask

    task automatic test_invalid_and_change();
        int pulses = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin run_cycle(); void'(exp_q.pop_front()); end
        rst = 0; directions = 4'b1100;
        for (int i = 0; i < 20; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (step_pulse) pulses++;
            if (obs_v !== exp_v) $display("FAIL invalid_code cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL invalid_no_step: got pulses=%0d want 0", pulses);
        else passes++;
        directions = DIR_DOWN;
        for (int i = 0; i < 100 && ey != 6; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== exp_v) $display("FAIL down_to_6 cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        checks++;
        if (cur_y !== 3'd6) $display("FAIL down_reach: got y=%0d want 6", cur_y);
        else passes++;
        for (int i = 0; i < 33; i++) begin
            directions = (i < 3) ? DIR_NONE : DIR_UP;
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== exp_v) $display("FAIL up_repeat cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        directions = DIR_DOWN;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== exp_v) $display("FAIL switch_down cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
            if (i == 2) begin
                checks++;
                if (step_pulse !== 1'b1 || step_dir !== DIR_DOWN)
                    $display("FAIL switch_step: got p=%0b dir=%b want 1 0010", step_pulse, step_dir);
                else passes++;
            end
            if (i > 2 && step_pulse) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL switch_hold_restart: got pulses=%0d want 0", pulses);
        else passes++;
    endtask

    task automatic test_reset_mid();
        rst = 1; directions = DIR_NONE;
        for (int i = 0; i < 2; i++) begin run_cycle(); void'(exp_q.pop_front()); end
        rst = 0; directions = DIR_RIGHT;
        for (int i = 0; i < 100 && ex != 5; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== exp_v) $display("FAIL mid_right cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        directions = DIR_NONE;
        for (int i = 0; i < 2; i++) begin run_cycle(); void'(exp_q.pop_front()); end
        directions = DIR_DOWN;
        for (int i = 0; i < 100 && ey != 3; i++) begin
            run_cycle(); exp_v = exp_q.pop_front(); checks++;
            if (obs_v !== exp_v) $display("FAIL mid_down cyc %0d: got %b want %b", i, obs_v, exp_v);
            else passes++;
        end
        run_cycle(); void'(exp_q.pop_front());
        checks++;
        if (cur_x !== 3'd5 || cur_y !== 3'd3 || fsm_state !== ST_REPEAT)
            $display("FAIL mid_setup: got x=%0d y=%0d st=%0d want 5 3 2", cur_x, cur_y, fsm_state);
        else passes++;
        rst = 1;
        run_cycle(); void'(exp_q.pop_front()); checks++;
        if (obs_v !== 13'd0) $display("FAIL mid_reset: got %b want %b", obs_v, 13'd0);
        else passes++;
        rst = 0;
        run_cycle(); void'(exp_q.pop_front()); checks++;
        if (step_pulse !== 1'b0 || cur_y !== 3'd0) $display("FAIL post_reset_capture: got p=%0b y=%0d want 0 0", step_pulse, cur_y);
        else passes++;
        run_cycle(); void'(exp_q.pop_front()); checks++;
        if (step_pulse !== 1'b1 || cur_y !== 3'd1 || cur_x !== 3'd0)
            $display("FAIL post_reset_step: got p=%0b x=%0d y=%0d want 1 0 1", step_pulse, cur_x, cur_y);
        else passes++;
    endtask

    task automatic test_random();
        logic [3:0] pick[8];
        int len;
        pick = '{DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_UP, DIR_NONE, 4'b1100, 4'b0011, 4'b1111};
        for (int seg = 0; seg < 60; seg++) begin
            directions = pick[$urandom_range(0, 7)];
            enable     = ($urandom_range(0, 9) != 0);
            len        = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 149) == 0);
                run_cycle(); exp_v = exp_q.pop_front(); checks++;
                if (obs_v !== exp_v) $display("FAIL random seg %0d cyc %0d: got %b want %b", seg, i, obs_v, exp_v);
                else passes++;
            end
        end
        rst = 0; enable = 1; directions = DIR_NONE;
    endtask

    initial begin
        rst = 1; directions = DIR_NONE; enable = 1;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_hold_saturate();
        test_left_edge();
        test_invalid_and_change();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
